// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a fetch and a data requester, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise data has fixed priority over fetch.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// REQ   | request presented on mem_*, waiting for mem_req_ready_i
// WAIT  | request accepted, waiting for mem_resp_valid_i
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_data_valid_o,
  input  logic                d_req_valid_i,
  input  logic                d_wen_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_data_valid_o,
  output logic                mem_req_valid_o,
  output logic                mem_wen_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner_data;
  logic   discard;
  logic   if_pend, d_pend, grant_any, grant_data, flush_hit;

  // A requester whose completion pulse is out this cycle is still holding its old request.
  assign if_pend   = if_req_valid_i & ~if_data_valid_o;
  assign d_pend    = d_req_valid_i & ~d_data_valid_o;
  assign grant_any = if_pend | d_pend;
  assign flush_hit = if_flush_i & ~owner_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b1;
    end else if (state == IDLE && grant_any) begin
      last_data <= grant_data;
    end
  end

  assign grant_data = d_pend & (~if_pend | ~last_data);
`else
  assign grant_data = d_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = REQ;
      REQ:     if (mem_req_ready_i) state_nxt = WAIT;
      WAIT:    if (mem_resp_valid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_data      <= 1'b0;
      discard         <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_wen_o       <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      mem_wstrb_o     <= '0;
      if_data_o       <= '0;
      if_data_valid_o <= 1'b0;
      d_rdata_o       <= '0;
      d_data_valid_o  <= 1'b0;
    end else begin
      if_data_valid_o <= 1'b0;
      d_data_valid_o  <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grant_any) begin
            owner_data      <= grant_data;
            mem_req_valid_o <= 1'b1;
            mem_wen_o       <= grant_data & d_wen_i;
            mem_addr_o      <= grant_data ? d_addr_i : if_addr_i;
            mem_wdata_o     <= grant_data ? d_wdata_i : '0;
            mem_wstrb_o     <= grant_data ? d_wstrb_i : '0;
          end
        end
        REQ: begin
          if (flush_hit) discard <= 1'b1;
          if (mem_req_ready_i) mem_req_valid_o <= 1'b0;
        end
        WAIT: begin
          if (flush_hit) discard <= 1'b1;
          if (mem_resp_valid_i) begin
            discard <= 1'b0;
            if (owner_data) begin
              d_data_valid_o <= 1'b1;
              if (!mem_wen_o) d_rdata_o <= mem_rdata_i;
            end else if (!(discard | flush_hit)) begin
              if_data_o       <= mem_rdata_i;
              if_data_valid_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid_i, if_flush_i, if_data_valid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          d_req_valid_i, d_wen_i, d_data_valid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic [SW-1:0] d_wstrb_i;
  logic          mem_req_valid_o, mem_wen_o, mem_req_ready_i, mem_resp_valid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [SW-1:0] mem_wstrb_o;
  logic          busy_o;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_data_valid_o(if_data_valid_o),
    .d_req_valid_i(d_req_valid_i), .d_wen_i(d_wen_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o),
    .d_data_valid_o(d_data_valid_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid_i = 0; if_addr_i = '0; if_flush_i = 0;
    d_req_valid_i = 0; d_wen_i = 0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    if_req_valid_i = 1; d_req_valid_i = 1; mem_req_ready_i = 1; mem_resp_valid_i = 1;
    mem_rdata_i = 32'hFFFF_FFFF;
    step(); step();
    checks++;
    if ({mem_req_valid_o, mem_wen_o, busy_o, if_data_valid_o, d_data_valid_o} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000",
               {mem_req_valid_o, mem_wen_o, busy_o, if_data_valid_o, d_data_valid_o});
    checks++;
    if (if_data_o !== '0) $display("FAIL reset_if_data got=%h exp=0", if_data_o);
    checks++;
    if (d_rdata_o !== '0) $display("FAIL reset_d_rdata got=%h exp=0", d_rdata_o);
    checks++;
    if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0)
      $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr_o, mem_wdata_o, mem_wstrb_o});
    failures += 0;
    if ({mem_req_valid_o, busy_o, if_data_valid_o, d_data_valid_o} !== 4'b0 || if_data_o !== '0 ||
        d_rdata_o !== '0 || {mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) failures++;
    rst = 0; clear_inputs(); step();
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req_valid_i = 1; if_addr_i = 32'h8000_0000;
    step();
    checks++;
    if ({mem_req_valid_o, mem_wen_o, mem_addr_o} !== {1'b1, 1'b0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL fetch_issue got=%h exp=%h", {mem_req_valid_o, mem_wen_o, mem_addr_o},
               {1'b1, 1'b0, 32'h8000_0000});
    end
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL fetch_busy got=%b exp=1", busy_o); end
    mem_req_ready_i = 1;
    step();
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL fetch_valid_drop got=%b exp=0", mem_req_valid_o);
    end
    mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h0010_0093;
    step();
    checks++;
    if ({if_data_valid_o, d_data_valid_o, if_data_o} !== {2'b10, 32'h0010_0093}) begin
      failures++;
      $display("FAIL fetch_data_c3 got=%h exp=%h", {if_data_valid_o, d_data_valid_o, if_data_o},
               {2'b10, 32'h0010_0093});
    end
    if_req_valid_i = 0; mem_resp_valid_i = 0;
    step();
    checks++;
    if ({if_data_valid_o, busy_o, if_data_o} !== {2'b00, 32'h0010_0093}) begin
      failures++;
      $display("FAIL fetch_after got=%h exp=%h", {if_data_valid_o, busy_o, if_data_o},
               {2'b00, 32'h0010_0093});
    end
  endtask

  task automatic test_priority();
    bit first_d;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 0;
`else
    first_d = 1;
`endif
    do_reset();
    if_req_valid_i = 1; if_addr_i = 32'h8000_0004;
    d_req_valid_i = 1; d_wen_i = 0; d_addr_i = 32'h8000_1000;
    for (int t = 0; t < 2; t++) begin
      bit is_d = (t == 0) ? first_d : !first_d;
      step();
      checks++;
      if ({mem_req_valid_o, mem_addr_o} !== {1'b1, is_d ? 32'h8000_1000 : 32'h8000_0004}) begin
        failures++;
        $display("FAIL prio_order%0d got=%h exp=%h", t, {mem_req_valid_o, mem_addr_o},
                 {1'b1, is_d ? 32'h8000_1000 : 32'h8000_0004});
      end
      mem_req_ready_i = 1;
      step();
      mem_req_ready_i = 0; mem_resp_valid_i = 1;
      mem_rdata_i = is_d ? 32'h1111_2222 : 32'h3333_4444;
      step();
      mem_resp_valid_i = 0;
      checks++;
      if (is_d) begin
        if ({if_data_valid_o, d_data_valid_o, d_rdata_o} !== {2'b01, 32'h1111_2222}) begin
          failures++;
          $display("FAIL prio_load%0d got=%h exp=%h", t, {if_data_valid_o, d_data_valid_o, d_rdata_o},
                   {2'b01, 32'h1111_2222});
        end
        d_req_valid_i = 0;
      end else begin
        if ({if_data_valid_o, d_data_valid_o, if_data_o} !== {2'b10, 32'h3333_4444}) begin
          failures++;
          $display("FAIL prio_fetch%0d got=%h exp=%h", t, {if_data_valid_o, d_data_valid_o, if_data_o},
                   {2'b10, 32'h3333_4444});
        end
        if_req_valid_i = 0;
      end
    end
    step();
  endtask

  task automatic test_store_stall();
    d_req_valid_i = 1; d_wen_i = 1; d_addr_i = 32'h8000_2000;
    d_wdata_i = 32'hDEAD_BEEF; d_wstrb_i = 4'hF;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !==
          {2'b11, 32'h8000_2000, 32'hDEAD_BEEF, 4'hF}) begin
        failures++;
        $display("FAIL store_stable%0d got=%h exp=%h", i,
                 {mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wstrb_o},
                 {2'b11, 32'h8000_2000, 32'hDEAD_BEEF, 4'hF});
      end
      step();
    end
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h5555_5555;
    step();
    mem_resp_valid_i = 0;
    checks++;
    if ({if_data_valid_o, d_data_valid_o, d_rdata_o} !== {2'b01, 32'h1111_2222}) begin
      failures++;
      $display("FAIL store_ack got=%h exp=%h", {if_data_valid_o, d_data_valid_o, d_rdata_o},
               {2'b01, 32'h1111_2222});
    end
    d_req_valid_i = 0; d_wen_i = 0;
    step();
    checks++;
    if (d_data_valid_o !== 1'b0) begin
      failures++; $display("FAIL store_single_pulse got=%b exp=0", d_data_valid_o);
    end
  endtask

  task automatic test_flush();
    if_req_valid_i = 1; if_addr_i = 32'h8000_0010;
    step();
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0; if_flush_i = 1; if_req_valid_i = 0;
    step();
    if_flush_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h7777_7777;
    step();
    mem_resp_valid_i = 0;
    checks++;
    if ({if_data_valid_o, busy_o, if_data_o} !== {2'b00, 32'h3333_4444}) begin
      failures++;
      $display("FAIL flush_discard got=%h exp=%h", {if_data_valid_o, busy_o, if_data_o},
               {2'b00, 32'h3333_4444});
    end
    d_req_valid_i = 1; d_wen_i = 0; d_addr_i = 32'h8000_3000;
    step();
    checks++;
    if ({mem_req_valid_o, mem_wen_o, mem_addr_o} !== {2'b10, 32'h8000_3000}) begin
      failures++;
      $display("FAIL flush_next_issue got=%h exp=%h", {mem_req_valid_o, mem_wen_o, mem_addr_o},
               {2'b10, 32'h8000_3000});
    end
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h1234_5678;
    step();
    mem_resp_valid_i = 0;
    checks++;
    if ({if_data_valid_o, d_data_valid_o, d_rdata_o} !== {2'b01, 32'h1234_5678}) begin
      failures++;
      $display("FAIL flush_next_data got=%h exp=%h", {if_data_valid_o, d_data_valid_o, d_rdata_o},
               {2'b01, 32'h1234_5678});
    end
    d_req_valid_i = 0;
    step();
    if_req_valid_i = 1; if_addr_i = 32'h8000_0020;
    step();
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'h9999_9999;
    if_flush_i = 1; if_req_valid_i = 0;
    step();
    if_flush_i = 0; mem_resp_valid_i = 0;
    checks++;
    if ({if_data_valid_o, if_data_o} !== {1'b0, 32'h3333_4444}) begin
      failures++;
      $display("FAIL flush_same_cycle got=%h exp=%h", {if_data_valid_o, if_data_o},
               {1'b0, 32'h3333_4444});
    end
    step();
    checks++;
    if ({if_data_valid_o, busy_o} !== 2'b00) begin
      failures++; $display("FAIL flush_late_pulse got=%b exp=00", {if_data_valid_o, busy_o});
    end
  endtask

  task automatic test_reset_in_wait();
    if_req_valid_i = 1; if_addr_i = 32'h8000_0030;
    step();
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0; rst = 1; if_req_valid_i = 0;
    step();
    checks++;
    if ({mem_req_valid_o, mem_wen_o, busy_o, if_data_valid_o, d_data_valid_o, if_data_o, d_rdata_o,
         mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs got=%h exp=0", {mem_req_valid_o, busy_o, if_data_o, d_rdata_o,
               mem_addr_o});
    end
    rst = 0; mem_resp_valid_i = 1; mem_rdata_i = 32'hCAFE_BABE;
    step();
    mem_resp_valid_i = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({if_data_valid_o, d_data_valid_o, mem_req_valid_o, busy_o, if_data_o} !== '0) begin
        failures++;
        $display("FAIL rst_wait_late%0d got=%h exp=0", i,
                 {if_data_valid_o, d_data_valid_o, mem_req_valid_o, busy_o, if_data_o});
      end
      step();
    end
  endtask

  task automatic test_random(input int n);
    bit if_act = 0, d_act = 0, if_done, d_done;
    logic [AW-1:0] if_a = '0, d_a = '0;
    logic d_w = 0;
    logic [DW-1:0] d_wd = '0;
    logic [SW-1:0] d_ws = '0;
    bit bus_free = 1, req_open = 0, waiting = 0, own_d = 0, disc = 0, last_d = 1;
    int cd = 0;
    logic [AW-1:0] e_addr = '0;
    logic e_wen = 0;
    logic [DW-1:0] e_wdata = '0;
    logic [SW-1:0] e_wstrb = '0;
    bit pulse_if = 0, pulse_d = 0;
    logic [DW-1:0] m_if = '0, m_d = '0;
    do_reset();
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({mem_req_valid_o, busy_o} !== {req_open, !bus_free}) begin
        failures++;
        $display("FAIL rnd_handshake c%0d got=%b exp=%b", k, {mem_req_valid_o, busy_o},
                 {req_open, !bus_free});
      end
      if (req_open) begin
        checks++;
        if ({mem_wen_o, mem_addr_o} !== {e_wen, e_addr}) begin
          failures++;
          $display("FAIL rnd_req c%0d got=%h exp=%h", k, {mem_wen_o, mem_addr_o}, {e_wen, e_addr});
        end
        if (e_wen) begin
          checks++;
          if ({mem_wdata_o, mem_wstrb_o} !== {e_wdata, e_wstrb}) begin
            failures++;
            $display("FAIL rnd_wdata c%0d got=%h exp=%h", k, {mem_wdata_o, mem_wstrb_o},
                     {e_wdata, e_wstrb});
          end
        end
      end
      checks++;
      if ({if_data_valid_o, d_data_valid_o, if_data_o, d_rdata_o} !== {pulse_if, pulse_d, m_if, m_d}) begin
        failures++;
        $display("FAIL rnd_resp c%0d got=%h exp=%h", k,
                 {if_data_valid_o, d_data_valid_o, if_data_o, d_rdata_o}, {pulse_if, pulse_d, m_if, m_d});
      end

      if_done = pulse_if; d_done = pulse_d;
      if (pulse_if) if_act = 0;
      if (pulse_d) d_act = 0;
      if_flush_i = ($urandom_range(0, 7) == 0);
      if (if_flush_i && !bus_free && !own_d) begin
        disc = 1; if_act = 0; if_done = 1;
      end
      if (!if_act && !if_done && $urandom_range(0, 3) == 0) begin
        if_act = 1; if_a = $urandom;
      end
      if (!d_act && !d_done && $urandom_range(0, 3) == 0) begin
        d_act = 1; d_a = $urandom; d_w = 1'($urandom_range(0, 1));
        d_wd = $urandom; d_ws = SW'($urandom_range(1, 15));
      end
      if_req_valid_i = if_act; if_addr_i = if_act ? if_a : $urandom;
      d_req_valid_i = d_act; d_addr_i = d_a; d_wen_i = d_w; d_wdata_i = d_wd; d_wstrb_i = d_ws;
      mem_req_ready_i = 1'($urandom_range(0, 1));
      mem_resp_valid_i = 0; mem_rdata_i = $urandom;
      if (waiting) begin
        if (cd == 0) mem_resp_valid_i = 1;
        else cd--;
      end

      pulse_if = 0; pulse_d = 0;
      if (bus_free) begin
        if (if_act || d_act) begin
`ifdef ARB_ROUND_ROBIN_EN
          own_d = (if_act && d_act) ? !last_d : d_act;
          last_d = own_d;
`else
          own_d = d_act;
`endif
          e_wen = own_d && d_w; e_addr = own_d ? d_a : if_a;
          e_wdata = d_wd; e_wstrb = d_ws;
          req_open = 1; bus_free = 0; disc = 0;
        end
      end else if (req_open) begin
        if (mem_req_ready_i) begin
          req_open = 0; waiting = 1; cd = $urandom_range(0, 3);
        end
      end else if (waiting && mem_resp_valid_i) begin
        waiting = 0; bus_free = 1;
        if (own_d) begin
          pulse_d = 1;
          if (!e_wen) m_d = mem_rdata_i;
        end else if (!disc) begin
          pulse_if = 1; m_if = mem_rdata_i;
        end
      end
      step();
    end
    clear_inputs();
    do_reset();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_priority();
    test_store_stall();
    test_flush();
    test_reset_in_wait();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port if_req_valid_i  input  1  fetch request, held until if_data_valid_o.
REQ-006 SHALL have port if_addr_i  input  ADDR_W  fetch address, stable while if_req_valid_i high.
REQ-007 SHALL have port if_flush_i  input  1  CTRL flush; discard any outstanding fetch.
REQ-008 SHALL have port if_data_o  output  DATA_W  fetched instruction.
REQ-009 SHALL have port if_data_valid_o  output  1  one-cycle pulse, if_data_o valid.
REQ-010 SHALL have port d_req_valid_i  input  1  data request, held until d_data_valid_o.
REQ-011 SHALL have port d_wen_i  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr_i  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata_i  input  DATA_W  store data.
REQ-014 SHALL have port d_wstrb_i  input  DATA_W/8  store byte strobes.
REQ-015 SHALL have port d_rdata_o  output  DATA_W  load data.
REQ-016 SHALL have port d_data_valid_o  output  1  one-cycle pulse; load data valid or store acknowledged.
REQ-017 SHALL have port mem_req_valid_o / mem_wen_o / mem_addr_o / mem_wdata_o / mem_wstrb_o  output  1/1/ADDR_W/DATA_W/DATA_W/8  unified memory request, all registered.
REQ-018 SHALL have port mem_req_ready_i  input  1  memory accepts the request in the cycle it is high with mem_req_valid_o.
REQ-019 SHALL have port mem_resp_valid_i / mem_rdata_i  input  1/DATA_W  memory response; exactly one per accepted request.
REQ-020 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM IDLE, REQ, WAIT; at most one memory transaction outstanding.
REQ-022 In IDLE with one or more requests pending, SHALL select an owner, register its request on mem_* outputs, assert mem_req_valid_o and go to REQ in the next cycle.
REQ-023 In REQ, SHALL hold all mem_* outputs stable until mem_req_ready_i is high, then deassert mem_req_valid_o and go to WAIT.
REQ-024 In WAIT, on mem_resp_valid_i SHALL register mem_rdata_i to the owner's data output, pulse the owner's valid one cycle later, and return to IDLE.
REQ-025 Minimum latency from request to data valid SHALL be 3 cycles, with ready in the first REQ cycle and the response one cycle later.
REQ-026 On a store, SHALL pulse d_data_valid_o and leave d_rdata_o unchanged.
REQ-027 Data outputs SHALL hold their last value between pulses.
REQ-028 if_flush_i in REQ or WAIT with fetch owner SHALL mark the transaction discarded: the transaction completes on the bus, and if_data_valid_o is not pulsed.
REQ-029 if_flush_i in IDLE or with data owner SHALL have no effect.
REQ-030 if_flush_i and mem_resp_valid_i in the same cycle SHALL discard the response.
REQ-031 A new request arriving while busy SHALL wait; it SHALL be arbitrated in the first IDLE cycle.
REQ-032 Arbitration SHALL use only inputs sampled in IDLE.

Reset
REQ-033 rst high SHALL force IDLE, clear the discard flag, clear all outputs to 0 and set the round-robin pointer to data, overriding any in-flight transaction; no valid pulse SHALL follow a transaction aborted by reset.

Configuration
REQ-034 When macro ARB_ROUND_ROBIN_EN is defined and both requests are pending in IDLE, SHALL grant the requester not served most recently; the pointer updates on each grant.
REQ-035 When ARB_ROUND_ROBIN_EN is undefined, SHALL use fixed priority, with data always winning over fetch; the pointer logic SHALL be absent.

Verification
REQ-036 Single fetch: if_addr_i=0x80000000, ready immediate, response 0x00100093 one cycle later -> if_data_valid_o pulses in cycle 3 with if_data_o=0x00100093.
REQ-037 Simultaneous fetch 0x80000004 and load 0x80001000, fixed priority -> load issued first and fetch second; with ARB_ROUND_ROBIN_EN and pointer at data -> fetch issued first.
REQ-038 Store 0xDEADBEEF, strobe 0xF, ready held low 5 cycles -> mem_* outputs stable for all 5 cycles, then one d_data_valid_o pulse, with d_rdata_o unchanged.
REQ-039 Fetch outstanding in WAIT, if_flush_i pulsed -> response consumed, no if_data_valid_o pulse, busy_o falls, next request served normally.
REQ-040 rst asserted in WAIT -> next cycle all outputs are 0 and state is IDLE; a late mem_resp_valid_i produces no valid pulse.
